// File: rtl/fetch_line_buffer.sv
// Direct-mapped fetch line buffer: fills whole lines from memory and offers one instruction at a time to decode.
// Define FETCH_LINE_BUFFER_PREFETCH_EN to request the next sequential line as the last slot of a line issues.
module fetch_line_buffer #(
    parameter int ADDR_W    = 64,
    parameter int BUS_W     = 64,
    parameter int INSN_W    = 32,
    parameter int NUM_LINES = 4,
    parameter int MASK_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [MASK_W-1:0] redir_mask,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [BUS_W-1:0]  mem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [INSN_W-1:0] dec_insn,
    output logic [MASK_W-1:0] dec_mask
);

    localparam int LB       = $clog2(BUS_W / 8);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W    = ADDR_W - LB - IDX_BITS;
    localparam int SLOT_LSB = $clog2(INSN_W / 8);
    localparam int SLOT_W   = $clog2(BUS_W / INSN_W);
    localparam logic [ADDR_W-1:0] INSN_STEP = ADDR_W'(INSN_W / 8);

    localparam logic [7:0] OP_HALT              = 8'h01;
    localparam logic [7:0] OP_JMP_ALWAYS        = 8'h20;
    localparam logic [7:0] OP_JMP_EQUAL         = 8'h21;
    localparam logic [7:0] OP_JMP_NOT_EQUAL     = 8'h22;
    localparam logic [7:0] OP_JMP_GREATER       = 8'h23;
    localparam logic [7:0] OP_JMP_GREATER_EQUAL = 8'h24;
    localparam logic [7:0] OP_JMP_LOWER         = 8'h25;
    localparam logic [7:0] OP_JMP_LOWER_EQUAL   = 8'h26;
    localparam logic [7:0] OP_LOAD_RESTORE_PC   = 8'h30;

    // state      | meaning
    // LOOKUP     | probe the buffer at fetch_pc
    // MEM_REQ    | line request held until memory accepts it
    // MEM_WAIT   | waiting for the one-cycle read response
    // ISSUE      | instruction offered to decode
    // WAIT_REDIR | control flow handed off, idle until the store stage redirects
    typedef enum logic [2:0] {
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        ISSUE,
        WAIT_REDIR
    } state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        if (IDX_BITS == 0) return '0;
        return a[LB +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:LB], {LB{1'b0}}};
    endfunction

    function automatic logic is_ctrl_flow(input logic [7:0] op);
        case (op)
            OP_HALT, OP_JMP_ALWAYS, OP_JMP_EQUAL, OP_JMP_NOT_EQUAL,
            OP_JMP_GREATER, OP_JMP_GREATER_EQUAL, OP_JMP_LOWER,
            OP_JMP_LOWER_EQUAL, OP_LOAD_RESTORE_PC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t              state_q;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [MASK_W-1:0]   mask_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [BUS_W-1:0]    line_data_q [NUM_LINES];
    logic [TAG_W-1:0]    line_tag_q  [NUM_LINES];
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_req_addr_q;
    logic                dec_valid_q;
    logic [ADDR_W-1:0]   dec_pc_q;
    logic [INSN_W-1:0]   dec_insn_q;
    logic [MASK_W-1:0]   dec_mask_q;

    logic [IDX_W-1:0]    cur_idx;
    logic [IDX_W-1:0]    fill_idx;
    logic [SLOT_W-1:0]   cur_slot;
    logic                cur_hit;
    logic [INSN_W-1:0]   cur_insn;
    logic [ADDR_W-1:0]   fetch_pc_d;

    assign cur_idx    = idx_of(fetch_pc_q);
    assign fill_idx   = idx_of(mem_req_addr_q);
    assign cur_slot   = fetch_pc_q[SLOT_LSB +: SLOT_W];
    assign cur_hit    = valid_q[cur_idx] && (line_tag_q[cur_idx] == tag_of(fetch_pc_q));
    assign cur_insn   = line_data_q[cur_idx][cur_slot*INSN_W +: INSN_W];
    assign fetch_pc_d = fetch_pc_q + INSN_STEP;

`ifdef FETCH_LINE_BUFFER_PREFETCH_EN
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(BUS_W / 8);

    logic [ADDR_W-1:0] next_line;
    logic [IDX_W-1:0]  next_idx;
    logic              pf_miss;

    assign next_line = line_of(fetch_pc_q) + LINE_STEP;
    assign next_idx  = idx_of(next_line);
    assign pf_miss   = (&cur_slot) &&
                       !(valid_q[next_idx] && (line_tag_q[next_idx] == tag_of(next_line)));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= LOOKUP;
            fetch_pc_q      <= '0;
            mask_q          <= '1;
            valid_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            dec_valid_q     <= 1'b0;
            dec_pc_q        <= '0;
            dec_insn_q      <= '0;
            dec_mask_q      <= '1;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (cur_hit) begin
                        dec_valid_q <= 1'b1;
                        dec_pc_q    <= fetch_pc_q;
                        dec_insn_q  <= cur_insn;
                        dec_mask_q  <= mask_q;
                        state_q     <= ISSUE;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= line_of(fetch_pc_q);
                        state_q         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= LOOKUP;
                    end
                end
                ISSUE: begin
                    if (dec_ready) begin
                        dec_valid_q <= 1'b0;
                        fetch_pc_q  <= fetch_pc_d;
                        if (is_ctrl_flow(dec_insn_q[7:0])) begin
                            state_q <= WAIT_REDIR;
                        end else begin
`ifdef FETCH_LINE_BUFFER_PREFETCH_EN
                            // fetch_pc_d already equals next_line here, so the fill serves the next lookup
                            if (pf_miss) begin
                                mem_req_valid_q <= 1'b1;
                                mem_req_addr_q  <= next_line;
                                state_q         <= MEM_REQ;
                            end else begin
                                state_q <= LOOKUP;
                            end
`else
                            state_q <= LOOKUP;
`endif
                        end
                    end
                end
                WAIT_REDIR: begin
                    if (redir_valid) begin
                        fetch_pc_q <= redir_pc;
                        mask_q     <= redir_mask;
                        state_q    <= LOOKUP;
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // Line payload and tags need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == MEM_WAIT && mem_rsp_valid) begin
            line_data_q[fill_idx] <= mem_rsp_data;
            line_tag_q[fill_idx]  <= tag_of(mem_req_addr_q);
        end
    end

`ifndef SYNTHESIS
    rsp_only_in_mem_wait: assert property (@(posedge clk) disable iff (!reset_n)
        mem_rsp_valid |-> state_q == MEM_WAIT);
`endif

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign dec_valid     = dec_valid_q;
    assign dec_pc        = dec_pc_q;
    assign dec_insn      = dec_insn_q;
    assign dec_mask      = dec_mask_q;

endmodule
